// File: rtl/fft_input_packer_if.sv
// Sample-in / vector-out bus of the FFT input packer.
// The packer uses the slave modport; the sample source and vector sink use master.
interface fft_input_packer_if #(
  parameter int DATA  = 9,
  parameter int ARRAY = 16
);
  logic                       din_valid;
  logic                       din_sof;
  logic signed [DATA-1:0]     din_re;
  logic signed [DATA-1:0]     din_im;
  logic                       valid_out;
  logic                       sof_out;
  logic [ARRAY-1:0][DATA-1:0] dout_re;
  logic [ARRAY-1:0][DATA-1:0] dout_im;
  logic                       frame_err;

  modport master (
    output din_valid, din_sof, din_re, din_im,
    input  valid_out, sof_out, dout_re, dout_im, frame_err
  );

  modport slave (
    input  din_valid, din_sof, din_re, din_im,
    output valid_out, sof_out, dout_re, dout_im, frame_err
  );
endinterface

// File: rtl/fft_input_packer.sv
// Packs 16 serial complex samples into one lane vector, 32 vectors per frame, with SOF alignment.
// Optional idle-gap abort is built when FFT_PACK_GAP_CHK_EN is defined.
module fft_input_packer #(
  parameter int DATA    = 9,
  parameter int ARRAY   = 16,
  parameter int FRAME   = 512,
  parameter int GAP_MAX = 64
) (
  input  logic               clk,
  input  logic               rstn,
  fft_input_packer_if.slave  bus
);
  localparam int NVEC   = FRAME / ARRAY;
  localparam int LANE_W = (ARRAY > 1) ? $clog2(ARRAY) : 1;
  localparam int VEC_W  = (NVEC > 1) ? $clog2(NVEC) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                     r_state;
  state_t                     w_nextState;
  logic [LANE_W-1:0]          r_laneCnt;
  logic [VEC_W-1:0]           r_vecCnt;
  logic [LANE_W-1:0]          w_lane;
  logic [VEC_W-1:0]           w_vec;
  logic [ARRAY-1:0][DATA-1:0] r_capRe;
  logic [ARRAY-1:0][DATA-1:0] r_capIm;
  logic [ARRAY-1:0][DATA-1:0] r_doutRe;
  logic [ARRAY-1:0][DATA-1:0] r_doutIm;
  logic                       r_validOut;
  logic                       r_sofOut;
  logic                       r_frameErr;
  logic                       w_accept;
  logic                       w_restart;
  logic                       w_lastLane;
  logic                       w_lastVec;
  logic                       w_abort;

`ifdef FFT_PACK_GAP_CHK_EN
  localparam int GAP_W = $clog2(GAP_MAX + 1);
  logic [GAP_W-1:0] r_gapCnt;

  // Consecutive idle cycles inside a frame; the GAP_MAX-th one aborts the frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_gapCnt <= '0;
    end else if (r_state != RUN || w_accept || w_abort) begin
      r_gapCnt <= '0;
    end else begin
      r_gapCnt <= r_gapCnt + 1'b1;
    end
  end

  assign w_abort = (r_state == RUN) && !bus.din_valid && (r_gapCnt == GAP_W'(GAP_MAX - 1));
`else
  logic [31:0] w_unusedGapMax;
  assign w_unusedGapMax = GAP_MAX;
  assign w_abort        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (w_accept) begin
      w_nextState = w_lastVec ? IDLE : RUN;
    end else if (w_abort) begin
      w_nextState = IDLE;
    end
  end

  // A SOF sample always lands in lane 0 of vector 0, whatever the counters held.
  always_comb begin
    w_accept   = bus.din_valid && (r_state == RUN || bus.din_sof);
    w_restart  = (r_state == RUN) && bus.din_valid && bus.din_sof &&
                 (r_vecCnt != '0 || r_laneCnt != '0);
    w_lane     = bus.din_sof ? '0 : r_laneCnt;
    w_vec      = bus.din_sof ? '0 : r_vecCnt;
    w_lastLane = w_accept && (w_lane == LANE_W'(ARRAY - 1));
    w_lastVec  = w_lastLane && (w_vec == VEC_W'(NVEC - 1));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_laneCnt  <= '0;
      r_vecCnt   <= '0;
      r_capRe    <= '0;
      r_capIm    <= '0;
      r_doutRe   <= '0;
      r_doutIm   <= '0;
      r_validOut <= 1'b0;
      r_sofOut   <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      r_validOut <= w_lastLane;
      r_sofOut   <= w_lastLane && (w_vec == '0);
      r_frameErr <= w_restart || w_abort;
      if (w_accept) begin
        r_capRe[w_lane] <= bus.din_re;
        r_capIm[w_lane] <= bus.din_im;
        if (w_lastLane) begin
          for (int k = 0; k < ARRAY; k++) begin
            r_doutRe[k] <= (k == ARRAY - 1) ? bus.din_re : r_capRe[k];
            r_doutIm[k] <= (k == ARRAY - 1) ? bus.din_im : r_capIm[k];
          end
          r_laneCnt <= '0;
          r_vecCnt  <= w_lastVec ? '0 : w_vec + 1'b1;
        end else begin
          r_laneCnt <= w_lane + 1'b1;
          r_vecCnt  <= w_vec;
        end
      end else if (w_abort) begin
        r_laneCnt <= '0;
        r_vecCnt  <= '0;
      end
    end
  end

  assign bus.valid_out = r_validOut;
  assign bus.sof_out   = r_sofOut;
  assign bus.dout_re   = r_doutRe;
  assign bus.dout_im   = r_doutIm;
  assign bus.frame_err = r_frameErr;
endmodule

// File: tb/tb_fft_input_packer.sv
// Scoreboard bench for fft_input_packer: drivers push expected vectors, a monitor pops on valid_out.
// The gap-abort scenario is exercised when FFT_PACK_GAP_CHK_EN is defined.
module tb_fft_input_packer;
  localparam int DATA  = 9;
  localparam int ARRAY = 16;
  localparam int FRAME = 512;

  typedef struct {
    logic [ARRAY-1:0][DATA-1:0] re;
    logic [ARRAY-1:0][DATA-1:0] im;
    logic                       sof;
    int                         cyc;
  } vec_t;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  vec_t expQ[$];
  int   nCompared    = 0;
  int   nMismatched  = 0;
  int   cycleCnt     = 0;
  int   errSeen      = 0;
  int   errExp       = 0;
  int   lastValidCyc = -1;

  always #5 clk = ~clk;

  fft_input_packer_if #(.DATA(DATA), .ARRAY(ARRAY)) bus ();

  fft_input_packer #(.DATA(DATA), .ARRAY(ARRAY), .FRAME(FRAME), .GAP_MAX(64)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always @(posedge clk) cycleCnt++;

  // Compare each presented vector with the oldest expectation: data, SOF flag, arrival cycle, spacing.
  task automatic checkOutput();
    vec_t e;
    if (expQ.size() == 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL unexpectedVector cycle=%0d got re=%h expected no vector", cycleCnt, bus.dout_re);
    end else begin
      e = expQ.pop_front();
      nCompared++;
      if (bus.dout_re !== e.re || bus.dout_im !== e.im) begin
        nMismatched++;
        $display("[TB] FAIL vecData cycle=%0d got re=%h im=%h expected re=%h im=%h",
                 cycleCnt, bus.dout_re, bus.dout_im, e.re, e.im);
      end
      nCompared++;
      if (bus.sof_out !== e.sof) begin
        nMismatched++;
        $display("[TB] FAIL sofOut cycle=%0d got %b expected %b", cycleCnt, bus.sof_out, e.sof);
      end
      nCompared++;
      if (cycleCnt != e.cyc) begin
        nMismatched++;
        $display("[TB] FAIL latency got cycle %0d expected cycle %0d", cycleCnt, e.cyc);
      end
    end
    if (lastValidCyc >= 0) begin
      nCompared++;
      if (cycleCnt - lastValidCyc < ARRAY) begin
        nMismatched++;
        $display("[TB] FAIL spacing got %0d cycles expected >= %0d", cycleCnt - lastValidCyc, ARRAY);
      end
    end
    lastValidCyc = cycleCnt;
  endtask

  always @(posedge clk) begin
    #1;
    if (bus.frame_err === 1'b1) errSeen++;
    if (bus.valid_out === 1'b1) checkOutput();
  end

  // Drive one cycle; called at posedge+1 and returns at the next posedge+1.
  task automatic applyStimulus(input logic v, input logic s, input logic [DATA-1:0] re,
                               input logic [DATA-1:0] im);
    bus.din_valid = v;
    bus.din_sof   = s;
    bus.din_re    = re;
    bus.din_im    = im;
    @(posedge clk);
    #1;
  endtask

  // Samples first..last-1 of a frame whose sample n carries re=base+n, im=-re; SOF on n==0.
  task automatic sendRange(input int base, input int first, input int last, input bit stall);
    logic [DATA-1:0] v;
    vec_t            e;
    for (int n = first; n < last; n++) begin
      if (stall) begin
        repeat ($urandom_range(0, 2))
          applyStimulus(1'b0, 1'($urandom_range(0, 1)), DATA'($urandom), DATA'($urandom));
      end
      v = DATA'(base + n);
      if (n % ARRAY == ARRAY - 1) begin
        for (int k = 0; k < ARRAY; k++) begin
          e.re[k] = DATA'(base + n - (ARRAY - 1) + k);
          e.im[k] = -e.re[k];
        end
        e.sof = (n < ARRAY);
        e.cyc = cycleCnt + 1;
        expQ.push_back(e);
      end
      applyStimulus(1'b1, n == 0, v, -v);
    end
    applyStimulus(1'b0, 1'b0, '0, '0);
  endtask

  task automatic finishTest(input string name);
    for (int i = 0; i < 64 && expQ.size() > 0; i++) applyStimulus(1'b0, 1'b0, '0, '0);
    repeat (3) applyStimulus(1'b0, 1'b0, '0, '0);
    nCompared++;
    if (expQ.size() != 0) begin
      nMismatched++;
      $display("[TB] FAIL %s_drain got %0d vectors outstanding expected 0", name, expQ.size());
      expQ.delete();
    end
    nCompared++;
    if (errSeen != errExp) begin
      nMismatched++;
      $display("[TB] FAIL %s_frameErr got %0d pulses expected %0d", name, errSeen, errExp);
      errSeen = errExp;
    end
  endtask

  task automatic checkOutputsZero(input string name);
    nCompared++;
    if (bus.valid_out !== 1'b0 || bus.sof_out !== 1'b0 || bus.frame_err !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL %s_flags got valid=%b sof=%b err=%b expected 0 0 0",
               name, bus.valid_out, bus.sof_out, bus.frame_err);
    end
    nCompared++;
    if (bus.dout_re !== '0 || bus.dout_im !== '0) begin
      nMismatched++;
      $display("[TB] FAIL %s_dout got re=%h im=%h expected 0", name, bus.dout_re, bus.dout_im);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.din_valid = 1'b0;
    bus.din_sof   = 1'b0;
    bus.din_re    = '0;
    bus.din_im    = '0;
    #1 rstn = 1'b0;
    #2 checkOutputsZero("reset");
    #9 rstn = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] contiguous frame");
    sendRange(0, 0, FRAME, 1'b0);
    finishTest("contiguous");

    $display("[TB] samples without sof in idle, then frame");
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, DATA'(i + 300), DATA'(i + 100));
    sendRange(600, 0, FRAME, 1'b0);
    finishTest("noSofIdle");

    $display("[TB] random stalls");
    sendRange(77, 0, FRAME, 1'b1);
    finishTest("stalls");

    $display("[TB] sof injected at sample 100");
    sendRange(1000, 0, 100, 1'b0);
    errExp++;
    sendRange(2000, 0, FRAME, 1'b0);
    finishTest("sofInject");

    $display("[TB] back-to-back frames");
    bus.din_valid = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int n = 0; n < FRAME; n++) begin
        vec_t            e;
        logic [DATA-1:0] v;
        v = DATA'(3000 + f * 1000 + n);
        if (n % ARRAY == ARRAY - 1) begin
          for (int k = 0; k < ARRAY; k++) begin
            e.re[k] = DATA'(3000 + f * 1000 + n - (ARRAY - 1) + k);
            e.im[k] = -e.re[k];
          end
          e.sof = (n < ARRAY);
          e.cyc = cycleCnt + 1;
          expQ.push_back(e);
        end
        applyStimulus(1'b1, n == 0, v, -v);
      end
    end
    finishTest("backToBack");

    $display("[TB] async reset at sample 300");
    sendRange(5000, 0, 300, 1'b0);
    #2 rstn = 1'b0;
    #1 checkOutputsZero("midReset");
    @(posedge clk);
    @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk);
    #1;
    sendRange(6000, 0, FRAME, 1'b0);
    finishTest("afterReset");

`ifdef FFT_PACK_GAP_CHK_EN
    $display("[TB] idle gap abort at sample 40");
    sendRange(7000, 0, 40, 1'b0);
    repeat (64) applyStimulus(1'b0, 1'b0, '0, '0);
    errExp++;
    for (int i = 0; i < ARRAY; i++) applyStimulus(1'b1, 1'b0, DATA'(7040 + i), DATA'(i));
    sendRange(7500, 0, FRAME, 1'b0);
    finishTest("gapAbort");
`else
    $display("[TB] long stall at sample 40");
    sendRange(7000, 0, 40, 1'b0);
    repeat (100) applyStimulus(1'b0, 1'b0, '0, '0);
    sendRange(7000, 40, FRAME, 1'b0);
    finishTest("longStall");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
